gerador_pwm_mod100: RTL and testbench

PWM generator directly downstream of the mod-100 duty counter. It consumes the 7-bit duty value (0..99 in normal use) and drives a fixed-period PWM waveform. The period is PERIODO counts, and each count lasts DIVISOR clocks. Duty changes are double-buffered and take effect only at a period boundary, so no runt or glitch pulses occur.

---
 rtl/gerador_pwm_mod100.sv | 97 +++++++++
 tb/tb_gerador_pwm_mod100.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gerador_pwm_mod100.sv
// gerador_pwm_mod100: fixed-period PWM generator fed by a mod-100 duty counter.
// The period lasts PERIODO counts and each count lasts DIVISOR clocks. The
// requested duty is double-buffered into r_duty_ativo. It changes only at a
// period wrap, or continuously while idle, so no runt pulses appear on saida_pwm.
// Optional build macro SAIDA_COMPLEMENTAR_EN adds a registered complementary
// output saida_pwm_n. It is low whenever the block is idle or in reset.
// habilita is a plain level enable, not a handshake. While it is low the block
// is held at count zero with both outputs low. The first clock with habilita
// high starts a fresh period at count zero.
module gerador_pwm_mod100 #(
  parameter int PERIODO         = 100,
  parameter int LARGURA         = 7,
  parameter int DIVISOR         = 1,
  parameter int DIVISOR_LARGURA = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               habilita,
  input  logic [LARGURA-1:0] ciclo_trabalho,
  output logic               saida_pwm,
  output logic               fim_periodo,
`ifdef SAIDA_COMPLEMENTAR_EN
  output logic               saida_pwm_n,
`endif
  output logic [LARGURA-1:0] contagem
);

  localparam logic [LARGURA-1:0]         PER_VAL = LARGURA'(PERIODO);
  localparam logic [LARGURA-1:0]         PER_MAX = LARGURA'(PERIODO - 1);
  localparam logic [DIVISOR_LARGURA-1:0] DIV_MAX = DIVISOR_LARGURA'(DIVISOR - 1);

  logic [DIVISOR_LARGURA-1:0] r_div;
  logic [LARGURA-1:0]         r_contagem;
  logic [LARGURA-1:0]         r_duty_ativo;
  logic                       r_saida_pwm;
  logic                       r_fim_periodo;
`ifdef SAIDA_COMPLEMENTAR_EN
  logic                       r_saida_pwm_n;
`endif

  logic                       w_tick;
  logic                       w_wrap;
  logic                       w_ativo;
  logic [LARGURA-1:0]         w_duty_clamp;

  // Decode the prescaler tick, the period wrap, the compare, and the clamped duty request.
  always_comb begin
    w_tick       = (r_div == DIV_MAX);
    w_wrap       = w_tick && (r_contagem == PER_MAX);
    w_ativo      = (r_contagem < r_duty_ativo);
    w_duty_clamp = (ciclo_trabalho > PER_VAL) ? PER_VAL : ciclo_trabalho;
  end

  // Prescaler, period counter, shadow duty and registered outputs. Idle overrides a coincident wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_div         <= '0;
      r_contagem    <= '0;
      r_duty_ativo  <= '0;
      r_saida_pwm   <= 1'b0;
      r_fim_periodo <= 1'b0;
`ifdef SAIDA_COMPLEMENTAR_EN
      r_saida_pwm_n <= 1'b0;
`endif
    end else if (!habilita) begin
      r_div         <= '0;
      r_contagem    <= '0;
      r_duty_ativo  <= w_duty_clamp;
      r_saida_pwm   <= 1'b0;
      r_fim_periodo <= 1'b0;
`ifdef SAIDA_COMPLEMENTAR_EN
      r_saida_pwm_n <= 1'b0;
`endif
    end else begin
      r_div <= w_tick ? '0 : r_div + DIVISOR_LARGURA'(1);
      if (w_tick) begin
        r_contagem <= w_wrap ? '0 : r_contagem + LARGURA'(1);
      end
      if (w_wrap) begin
        r_duty_ativo <= w_duty_clamp;
      end
      r_saida_pwm   <= w_ativo;
      r_fim_periodo <= w_wrap;
`ifdef SAIDA_COMPLEMENTAR_EN
      r_saida_pwm_n <= !w_ativo;
`endif
    end
  end

  assign saida_pwm   = r_saida_pwm;
  assign fim_periodo = r_fim_periodo;
  assign contagem    = r_contagem;
`ifdef SAIDA_COMPLEMENTAR_EN
  assign saida_pwm_n = r_saida_pwm_n;
`endif

endmodule

// File: tb/tb_gerador_pwm_mod100.sv
// Bench for gerador_pwm_mod100. It runs a DIVISOR=1 instance and a DIVISOR=4
// instance from shared inputs. A cycle model pushes expected outputs at each
// posedge, and the expected values are popped and compared at the next negedge.
// Scenario tasks add period-level checks.
module tb_gerador_pwm_mod100;

`ifdef SAIDA_COMPLEMENTAR_EN
  localparam int W = 10;
`else
  localparam int W = 9;
`endif

  logic       clock;
  logic       reset;
  logic       habilita;
  logic [6:0] ciclo_trabalho;
  logic [1:0] w_pwm;
  logic [1:0] w_fim;
  logic [6:0] w_cont0;
  logic [6:0] w_cont1;
`ifdef SAIDA_COMPLEMENTAR_EN
  logic [1:0] w_pwm_n;
`endif

  int n_errors = 0;
  int n_checks = 0;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  gerador_pwm_mod100 #(.PERIODO(100), .LARGURA(7), .DIVISOR(1), .DIVISOR_LARGURA(16)) dut1 (
    .clock(clock), .reset(reset), .habilita(habilita), .ciclo_trabalho(ciclo_trabalho),
    .saida_pwm(w_pwm[0]), .fim_periodo(w_fim[0]),
`ifdef SAIDA_COMPLEMENTAR_EN
    .saida_pwm_n(w_pwm_n[0]),
`endif
    .contagem(w_cont0)
  );

  gerador_pwm_mod100 #(.PERIODO(100), .LARGURA(7), .DIVISOR(4), .DIVISOR_LARGURA(16)) dut4 (
    .clock(clock), .reset(reset), .habilita(habilita), .ciclo_trabalho(ciclo_trabalho),
    .saida_pwm(w_pwm[1]), .fim_periodo(w_fim[1]),
`ifdef SAIDA_COMPLEMENTAR_EN
    .saida_pwm_n(w_pwm_n[1]),
`endif
    .contagem(w_cont1)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [15:0] div;
    logic [6:0]  cont;
    logic [6:0]  duty;
    logic        pwm;
    logic        fim;
    logic        pwm_n;
  } step_t;

  logic [15:0] m_div[2];
  logic [6:0]  m_cont[2];
  logic [6:0]  m_duty[2];

  function automatic step_t model_step(input int dv, input logic [15:0] d, input logic [6:0] c,
                                       input logic [6:0] duty, input logic hab, input logic [6:0] req);
    step_t r;
    logic  tick;
    logic  wrap;
    logic [6:0] clamp;
    clamp = (req > 7'd100) ? 7'd100 : req;
    tick  = (int'(d) == dv - 1);
    wrap  = tick && (c == 7'd99);
    if (!hab) begin
      r = '0;
      r.duty = clamp;
    end else begin
      r.div   = tick ? 16'd0 : d + 16'd1;
      r.cont  = tick ? (wrap ? 7'd0 : c + 7'd1) : c;
      r.duty  = wrap ? clamp : duty;
      r.pwm   = (c < duty);
      r.fim   = wrap;
      r.pwm_n = !(c < duty);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] pack_exp(input step_t r);
`ifdef SAIDA_COMPLEMENTAR_EN
    return {r.pwm_n, r.pwm, r.fim, r.cont};
`else
    return {r.pwm, r.fim, r.cont};
`endif
  endfunction

  function automatic logic [W-1:0] actual(input int k);
    logic [6:0] c;
    c = (k == 0) ? w_cont0 : w_cont1;
`ifdef SAIDA_COMPLEMENTAR_EN
    return {w_pwm_n[k], w_pwm[k], w_fim[k], c};
`else
    return {w_pwm[k], w_fim[k], c};
`endif
  endfunction

  // model update and expected-value push
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        m_div[k]  <= '0;
        m_cont[k] <= '0;
        m_duty[k] <= '0;
      end
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        step_t r;
        r = model_step((k == 0) ? 1 : 4, m_div[k], m_cont[k], m_duty[k], habilita, ciclo_trabalho);
        m_div[k]  <= r.div;
        m_cont[k] <= r.cont;
        m_duty[k] <= r.duty;
        if (k == 0) exp_q0.push_back(pack_exp(r));
        else        exp_q1.push_back(pack_exp(r));
      end
    end
  end

  // scoreboard compare
  always @(negedge clock) begin
    if (!reset) begin
      if (exp_q0.size() > 0) begin
        logic [W-1:0] e;
        e = exp_q0.pop_front();
        n_checks++;
        if (actual(0) !== e) begin
          n_errors++;
          $display("FAIL sb_div1 t=%0t got=%h exp=%h", $time, actual(0), e);
        end
      end
      if (exp_q1.size() > 0) begin
        logic [W-1:0] e;
        e = exp_q1.pop_front();
        n_checks++;
        if (actual(1) !== e) begin
          n_errors++;
          $display("FAIL sb_div4 t=%0t got=%h exp=%h", $time, actual(1), e);
        end
      end
    end
  end

  // ---------------- driver / scenario tasks ----------------
  task automatic wait_fim(input int k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (w_fim[k]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_fim k=%0d got=timeout exp=pulse", k);
    end
  endtask

  // Samples one period starting at a fim pulse; sample i has contagem = i/div.
  task automatic period(input int k, input int change_at, input logic [6:0] new_duty,
                        output int highs, output int fims);
    int len;
    len = (k == 0) ? 100 : 400;
    highs = 0;
    fims = 0;
    for (int i = 0; i < len; i++) begin
      if (w_pwm[k]) highs++;
      if (w_fim[k]) fims++;
      if (i == change_at) ciclo_trabalho = new_duty;
      @(negedge clock);
    end
  endtask

  task automatic measure(input int k, input int d);
    bit ok;
    int highs;
    int fims;
    int exp_h;
    exp_h = ((d > 100) ? 100 : d) * ((k == 0) ? 1 : 4);
    wait_fim(k, ok);
    if (ok) begin
      period(k, -1, 7'd0, highs, fims);
      n_checks++;
      if (highs !== exp_h) begin
        n_errors++;
        $display("FAIL high_clocks k=%0d duty=%0d got=%0d exp=%0d", k, d, highs, exp_h);
      end
      n_checks++;
      if (fims !== 1 || w_fim[k] !== 1'b1) begin
        n_errors++;
        $display("FAIL fim_spacing k=%0d got=%0d/%b exp=1/1", k, fims, w_fim[k]);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    habilita = 1'b1;
    repeat (2) @(negedge clock);
    n_checks++;
    if ({w_pwm, w_fim, w_cont0, w_cont1} !== '0) begin
      n_errors++;
      $display("FAIL reset_hold got=%h exp=0", {w_pwm, w_fim, w_cont0, w_cont1});
    end
    habilita = 1'b0;
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_duty(input int d);
    habilita = 1'b0;
    ciclo_trabalho = 7'(d);
    repeat (2) @(negedge clock);
    habilita = 1'b1;
    measure(0, d);
    measure(1, d);
  endtask

  task automatic test_mid_change;
    bit ok;
    int highs;
    int fims;
    habilita = 1'b0;
    ciclo_trabalho = 7'd25;
    repeat (2) @(negedge clock);
    habilita = 1'b1;
    wait_fim(0, ok);
    if (ok) begin
      period(0, 40, 7'd60, highs, fims);
      n_checks++;
      if (highs !== 25) begin
        n_errors++;
        $display("FAIL mid_change_old got=%0d exp=25", highs);
      end
      period(0, -1, 7'd0, highs, fims);
      n_checks++;
      if (highs !== 60) begin
        n_errors++;
        $display("FAIL mid_change_new got=%0d exp=60", highs);
      end
    end
  endtask

  task automatic test_idle_drop;
    bit ok;
    ok = 1'b0;
    ciclo_trabalho = 7'd25;
    for (int i = 0; i < 300; i++) begin
      if (w_cont0 == 7'd99) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL idle_wait got=timeout exp=contagem99");
    end
    habilita = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({w_fim[0], w_pwm[0], w_cont0} !== 9'd0) begin
      n_errors++;
      $display("FAIL idle_drop got=%h exp=0", {w_fim[0], w_pwm[0], w_cont0});
    end
`ifdef SAIDA_COMPLEMENTAR_EN
    n_checks++;
    if (w_pwm_n !== 2'b00) begin
      n_errors++;
      $display("FAIL idle_pwm_n got=%b exp=00", w_pwm_n);
    end
`endif
    repeat (3) @(negedge clock);
    habilita = 1'b1;
    @(negedge clock);
    n_checks++;
    if (w_pwm[0] !== 1'b1 || w_cont0 !== 7'd1) begin
      n_errors++;
      $display("FAIL reenable got=%b/%0d exp=1/1", w_pwm[0], w_cont0);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    ok = 1'b0;
    ciclo_trabalho = 7'd60;
    habilita = 1'b0;
    repeat (2) @(negedge clock);
    habilita = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (w_cont0 == 7'd50) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    n_checks++;
    if (!ok || w_pwm[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_mid_pre got=%b/%0d exp=1/50", w_pwm[0], w_cont0);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({w_pwm, w_fim, w_cont0, w_cont1} !== '0) begin
      n_errors++;
      $display("FAIL reset_async got=%h exp=0", {w_pwm, w_fim, w_cont0, w_cont1});
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if (w_cont0 !== 7'd1 || w_pwm[0] !== 1'b0 || w_fim[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release got=%0d/%b/%b exp=1/0/0", w_cont0, w_pwm[0], w_fim[0]);
    end
    repeat (5) @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    habilita = 1'b0;
    ciclo_trabalho = 7'd25;
    repeat (3) @(negedge clock);
    test_reset();
    test_duty(25);
    test_duty(0);
    test_duty(99);
    test_duty(100);
    test_duty(127);
    test_duty($urandom_range(1, 98));
    test_mid_change();
    test_idle_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
